linked_list_fifo_pop_sched: RTL and testbench

Round-robin pop scheduler for `linked_list_fifo`. It sits between the shared linked-list FIFO and a single downstream consumer. It snoops the push side to keep a shadow occupancy count per logical FIFO, and issues `pop`/`pop_fifo` only to non-empty, enabled FIFOs. It absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer, so the consumer sees a valid/ready stream tagged with the source FIFO id.

---
 rtl/linked_list_fifo_pop_sched_pkg.sv | 28 ++
 rtl/linked_list_fifo_pop_sched_rr_arb.sv | 37 +++
 rtl/linked_list_fifo_pop_sched.sv | 151 +++++++++++++++
 tb/tb_linked_list_fifo_pop_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/linked_list_fifo_pop_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : linked_list_fifo_pop_sched_pkg
// Brief   : Shared sizing helpers and types for the linked-list FIFO pop
//           scheduler.
// Rev     : 1.0 - initial release
// ============================================================================
package linked_list_fifo_pop_sched_pkg;

    localparam int SKID_DEPTH = 2;

    typedef logic [1:0] skid_occ_t;

    // Number of bits needed to represent value (same sizing as the FIFO).
    function automatic int log2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/linked_list_fifo_pop_sched_rr_arb.sv
`default_nettype none
// ============================================================================
// Module  : linked_list_fifo_rr_arb
// Brief   : Combinational round-robin arbiter; search starts one past rr_ptr.
// Rev     : 1.0 - initial release
// ============================================================================
module linked_list_fifo_rr_arb
    import linked_list_fifo_pop_sched_pkg::*;
#(
    parameter int FIFOS = 8,
    parameter int IDX_W = 4
) (
    input  logic [FIFOS-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    logic [FIFOS-1:0] w_rotated;
    int               w_start;

    always_comb begin
        w_start     = (int'(rr_ptr) + 1) % FIFOS;
        w_rotated   = FIFOS'({req, req} >> w_start);
        grant_valid = 1'b0;
        grant_idx   = '0;
        // Descending scan so the lowest rotated offset wins.
        for (int i = FIFOS - 1; i >= 0; i--) begin
            if (w_rotated[i]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'((w_start + i) % FIFOS);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/linked_list_fifo_pop_sched.sv
`default_nettype none
// ============================================================================
// Module  : linked_list_fifo_pop_sched
// Brief   : Round-robin pop scheduler with shadow counts and a 2-entry skid.
// Rev     : 1.0 - initial release
// ============================================================================
module linked_list_fifo_pop_sched
    import linked_list_fifo_pop_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int FIFOS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [log2(FIFOS-1):0]    push_fifo,
    input  logic [FIFOS-1:0]          enable,
    output logic                      pop,
    output logic [log2(FIFOS-1):0]    pop_fifo,
    input  logic [WIDTH-1:0]          q,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [log2(FIFOS-1):0]    out_fifo,
    input  logic                      out_ready,
    output logic [log2(DEPTH-1):0]    total,
    output logic                      error
);

    localparam int LOG2_FIFO  = log2(FIFOS - 1);
    localparam int LOG2_DEPTH = log2(DEPTH - 1);
    localparam int FW         = LOG2_FIFO + 1;
    localparam int CW         = LOG2_DEPTH + 1;

    logic [CW-1:0]    r_cnt [FIFOS];
    logic [FW-1:0]    r_rr_ptr;
    logic [FW-1:0]    r_infl_fifo;
    logic             r_pop_d;
    logic [WIDTH-1:0] r_skid_data [SKID_DEPTH];
    logic [FW-1:0]    r_skid_fifo [SKID_DEPTH];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    skid_occ_t        r_occ;

    logic [FIFOS-1:0] w_elig;
    logic [FIFOS-1:0] w_inc;
    logic [FIFOS-1:0] w_dec;
    logic             w_grant_valid;
    logic [FW-1:0]    w_grant_idx;
    logic             w_drain;
    logic [2:0]       w_inflight;
    logic             w_issue;
    logic             w_push_hit;
    logic             w_full;
    logic             w_push_ok;

    generate
        for (genvar f = 0; f < FIFOS; f++) begin : g_fifo
            assign w_elig[f] = enable[f] && (r_cnt[f] != '0);
            assign w_inc[f]  = w_push_ok && (push_fifo == FW'(f));
            assign w_dec[f]  = w_issue && (w_grant_idx == FW'(f));
        end
    endgenerate

    linked_list_fifo_rr_arb #(
        .FIFOS (FIFOS),
        .IDX_W (FW)
    ) u_rr_arb (
        .req         (w_elig),
        .rr_ptr      (r_rr_ptr),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    // Words in the read pipe (pop, pop_d) plus skid words never exceed two.
    assign w_drain    = out_valid && out_ready;
    assign w_inflight = 3'(r_occ) + 3'(pop) + 3'(r_pop_d);
    assign w_issue    = w_grant_valid && (w_inflight <= 3'd1 + 3'(w_drain));

    assign w_push_hit = push && (int'(push_fifo) < FIFOS);
    assign w_full     = (total == CW'(DEPTH));
    assign w_push_ok  = w_push_hit && (!w_full || w_issue);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFOS; i++) r_cnt[i] <= '0;
            total <= '0;
            error <= 1'b0;
        end else begin
            for (int i = 0; i < FIFOS; i++) begin
                if (w_inc[i] && !w_dec[i])
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                else if (!w_inc[i] && w_dec[i])
                    r_cnt[i] <= r_cnt[i] - 1'b1;
            end
            if (w_push_ok && !w_issue)
                total <= total + 1'b1;
            else if (!w_push_ok && w_issue)
                total <= total - 1'b1;
            if (w_push_hit && w_full && !w_issue)
                error <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop         <= 1'b0;
            pop_fifo    <= '0;
            r_rr_ptr    <= FW'(FIFOS - 1);
            r_pop_d     <= 1'b0;
            r_infl_fifo <= '0;
        end else begin
            pop     <= w_issue;
            r_pop_d <= pop;
            if (w_issue) begin
                pop_fifo <= w_grant_idx;
                r_rr_ptr <= w_grant_idx;
            end
            // Tag follows the word down the one-cycle FIFO read latency.
            if (pop)
                r_infl_fifo <= pop_fifo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_skid_data[i] <= '0;
                r_skid_fifo[i] <= '0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_occ    <= '0;
        end else begin
            if (r_pop_d) begin
                r_skid_data[r_wr_ptr] <= q;
                r_skid_fifo[r_wr_ptr] <= r_infl_fifo;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_drain)
                r_rd_ptr <= ~r_rd_ptr;
            r_occ <= r_occ + {1'b0, r_pop_d} - {1'b0, w_drain};
        end
    end

    assign out_valid = (r_occ != '0);
    assign out_data  = r_skid_data[r_rd_ptr];
    assign out_fifo  = r_skid_fifo[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_linked_list_fifo_pop_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_linked_list_fifo_pop_sched
// Brief   : Directed bench for the pop scheduler with a behavioural FIFO model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_linked_list_fifo_pop_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic [3:0] push_fifo;
    logic [7:0] din;
    logic [7:0] enable;
    logic       pop;
    logic [3:0] pop_fifo;
    logic [7:0] q;
    logic       out_valid;
    logic [7:0] out_data;
    logic [3:0] out_fifo;
    logic       out_ready;
    logic [5:0] total;
    logic       error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    linked_list_fifo_pop_sched #(.WIDTH(8), .DEPTH(32), .FIFOS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_fifo (push_fifo),
        .enable    (enable),
        .pop       (pop),
        .pop_fifo  (pop_fifo),
        .q         (q),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_fifo  (out_fifo),
        .out_ready (out_ready),
        .total     (total),
        .error     (error)
    );

    // Behavioural shared FIFO: per-queue storage, q valid the cycle after pop.
    logic [7:0] mem [8][64];
    int         wp [8];
    int         rp [8];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int f = 0; f < 8; f++) begin
                wp[f] <= 0;
                rp[f] <= 0;
            end
            q <= 8'd0;
        end else begin
            if (push && push_fifo < 4'd8) begin
                mem[push_fifo[2:0]][wp[push_fifo[2:0]] % 64] <= din;
                wp[push_fifo[2:0]] <= wp[push_fifo[2:0]] + 1;
            end
            if (pop) begin
                q <= mem[pop_fifo[2:0]][rp[pop_fifo[2:0]] % 64];
                rp[pop_fifo[2:0]] <= rp[pop_fifo[2:0]] + 1;
            end
        end
    end

    // Output beat log and pop counter (monotonic; scenarios use offsets).
    int         cyc = 0;
    int         beat_n = 0;
    int         pop_n = 0;
    logic [7:0] beat_d [256];
    logic [3:0] beat_f [256];
    int         beat_t [256];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (out_valid && out_ready) begin
                beat_d[beat_n % 256] <= out_data;
                beat_f[beat_n % 256] <= out_fifo;
                beat_t[beat_n % 256] <= cyc;
                beat_n <= beat_n + 1;
            end
            if (pop)
                pop_n <= pop_n + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_w(input logic [3:0] f, input logic [7:0] d);
        push      = 1'b1;
        push_fifo = f;
        din       = d;
        @(negedge clk);
        push      = 1'b0;
    endtask

    task automatic wait_beats(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (beat_n < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, " beat timeout"}, 32'(beat_n >= target), 32'd1);
    endtask

    task automatic chk_beat(input string name, input int idx, input logic [7:0] d, input logic [3:0] f);
        chk({name, " data"}, 32'(beat_d[idx % 256]), 32'(d));
        chk({name, " fifo"}, 32'(beat_f[idx % 256]), 32'(f));
    endtask

    typedef struct {
        logic       push;
        logic [3:0] pf;
        logic [7:0] d;
        logic       rdy;
        logic       e_pop;
        logic [3:0] e_pf;
        logic       e_ov;
        logic [7:0] e_data;
        logic [3:0] e_fifo;
        logic [5:0] e_total;
    } vec_t;

    vec_t vt [7];

    initial begin
        int b;
        int p0;

        // Row r: expected outputs after r edges, then inputs for the next edge.
        vt[0] = '{1'b1, 4'd0, 8'd5, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 4'd0, 6'd0};
        vt[1] = '{1'b1, 4'd0, 8'd6, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 4'd0, 6'd1};
        vt[2] = '{1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 4'd0, 1'b0, 8'd0, 4'd0, 6'd1};
        vt[3] = '{1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 4'd0, 1'b0, 8'd0, 4'd0, 6'd0};
        vt[4] = '{1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 4'd0, 1'b1, 8'd5, 4'd0, 6'd0};
        vt[5] = '{1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 4'd0, 1'b1, 8'd6, 4'd0, 6'd0};
        vt[6] = '{1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 4'd0, 6'd0};

        rst       = 1'b1;
        push      = 1'b0;
        push_fifo = 4'd0;
        din       = 8'd0;
        enable    = 8'hFF;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        chk("reset pop",       32'(pop),       32'd0);
        chk("reset pop_fifo",  32'(pop_fifo),  32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data",  32'(out_data),  32'd0);
        chk("reset out_fifo",  32'(out_fifo),  32'd0);
        chk("reset total",     32'(total),     32'd0);
        chk("reset error",     32'(error),     32'd0);
        rst = 1'b0;

        for (int r = 0; r < 7; r++) begin
            chk($sformatf("vec%0d pop", r), 32'(pop), 32'(vt[r].e_pop));
            if (vt[r].e_pop)
                chk($sformatf("vec%0d pop_fifo", r), 32'(pop_fifo), 32'(vt[r].e_pf));
            chk($sformatf("vec%0d out_valid", r), 32'(out_valid), 32'(vt[r].e_ov));
            if (vt[r].e_ov) begin
                chk($sformatf("vec%0d out_data", r), 32'(out_data), 32'(vt[r].e_data));
                chk($sformatf("vec%0d out_fifo", r), 32'(out_fifo), 32'(vt[r].e_fifo));
            end
            chk($sformatf("vec%0d total", r), 32'(total), 32'(vt[r].e_total));
            push      = vt[r].push;
            push_fifo = vt[r].pf;
            din       = vt[r].d;
            out_ready = vt[r].rdy;
            @(negedge clk);
        end

        // Round robin across FIFOs 0, 3, 7, then 7 and 0.
        b = beat_n;
        push_w(4'd0, 8'h10);
        push_w(4'd3, 8'h13);
        push_w(4'd7, 8'h17);
        wait_beats("rr1", b + 3, 30);
        chk_beat("rr1 beat0", b,     8'h10, 4'd0);
        chk_beat("rr1 beat1", b + 1, 8'h13, 4'd3);
        chk_beat("rr1 beat2", b + 2, 8'h17, 4'd7);

        b = beat_n;
        push_w(4'd7, 8'h27);
        push_w(4'd0, 8'h20);
        wait_beats("rr2", b + 2, 30);
        chk_beat("rr2 beat0", b,     8'h27, 4'd7);
        chk_beat("rr2 beat1", b + 1, 8'h20, 4'd0);

        // Both pending at once with last grant 0: search from 1 picks 3 first.
        enable = 8'h00;
        b = beat_n;
        push_w(4'd7, 8'h37);
        push_w(4'd3, 8'h33);
        enable = 8'hFF;
        wait_beats("rr3", b + 2, 30);
        chk_beat("rr3 beat0", b,     8'h33, 4'd3);
        chk_beat("rr3 beat1", b + 1, 8'h37, 4'd7);
        chk("rr3 total", 32'(total), 32'd0);

        // Back-pressure: only two words outstanding, head frozen.
        out_ready = 1'b0;
        p0 = pop_n;
        b  = beat_n;
        push_w(4'd1, 8'h31);
        push_w(4'd1, 8'h32);
        push_w(4'd1, 8'h33);
        push_w(4'd1, 8'h34);
        repeat (10) @(negedge clk);
        chk("stall pops",      32'(pop_n - p0), 32'd2);
        chk("stall out_valid", 32'(out_valid),  32'd1);
        chk("stall out_data",  32'(out_data),   32'h31);
        repeat (3) @(negedge clk);
        chk("stall data held", 32'(out_data),   32'h31);
        chk("stall fifo held", 32'(out_fifo),   32'd1);
        chk("stall total",     32'(total),      32'd2);
        out_ready = 1'b1;
        wait_beats("stall", b + 4, 30);
        chk_beat("stall beat0", b,     8'h31, 4'd1);
        chk_beat("stall beat1", b + 1, 8'h32, 4'd1);
        chk_beat("stall beat2", b + 2, 8'h33, 4'd1);
        chk_beat("stall beat3", b + 3, 8'h34, 4'd1);
        chk("stall back-to-back", 32'(beat_t[(b + 1) % 256] - beat_t[b % 256]), 32'd1);

        // Enable mask: FIFO 0 held back until re-enabled.
        enable = 8'hFE;
        b = beat_n;
        push_w(4'd0, 8'h40);
        push_w(4'd2, 8'h42);
        repeat (12) @(negedge clk);
        chk("mask beats", 32'(beat_n - b), 32'd1);
        chk_beat("mask beat0", b, 8'h42, 4'd2);
        chk("mask total", 32'(total), 32'd1);
        enable = 8'hFF;
        wait_beats("unmask", b + 2, 30);
        chk_beat("unmask beat", b + 1, 8'h40, 4'd0);
        chk("unmask total", 32'(total), 32'd0);

        // Fill to DEPTH with no pops, then overflow.
        enable = 8'h00;
        for (int i = 0; i < 32; i++)
            push_w(4'd5, 8'(i));
        chk("full total", 32'(total), 32'd32);
        chk("full error", 32'(error), 32'd0);
        push_w(4'd5, 8'hAA);
        chk("ovf total", 32'(total), 32'd32);
        chk("ovf error", 32'(error), 32'd1);
        repeat (5) @(negedge clk);
        chk("ovf error sticky", 32'(error), 32'd1);

        // Reset with the skid full under back-pressure.
        out_ready = 1'b0;
        enable    = 8'hFF;
        repeat (8) @(negedge clk);
        chk("pre-rst out_valid", 32'(out_valid), 32'd1);
        chk("pre-rst total",     32'(total),     32'd30);
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst pop",       32'(pop),       32'd0);
        chk("async rst total",     32'(total),     32'd0);
        chk("async rst error",     32'(error),     32'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        p0 = pop_n;
        b  = beat_n;
        repeat (10) @(negedge clk);
        chk("post-rst pops",  32'(pop_n - p0),  32'd0);
        chk("post-rst beats", 32'(beat_n - b),  32'd0);
        push_w(4'd6, 8'h66);
        wait_beats("post-rst", b + 1, 30);
        chk_beat("post-rst beat", b, 8'h66, 4'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
